// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the register file.
// The WB stage has priority. Auxiliary writes wait in a small FIFO until
// the port is free. A starvation counter forces an aux write by stalling
// the pipeline. The block also flags ID-stage reads that match a buffered
// aux destination.
module rf_write_arbiter #(
  parameter int DEPTH    = 2,   // aux FIFO entries, power of two, >= 2
  parameter int MAX_WAIT = 4,   // denied cycles before a forced grant, >= 1
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,            // asynchronous, active low
  input  logic                       pipe_wb_en,
  input  logic [ADDR_W-1:0]          pipe_wb_dest,
  input  logic [DATA_W-1:0]          pipe_wb_value,
  input  logic                       aux_valid,
  input  logic [ADDR_W-1:0]          aux_dest,
  input  logic [DATA_W-1:0]          aux_value,
  output logic                       aux_ready,
  input  logic [ADDR_W-1:0]          src1,
  input  logic [ADDR_W-1:0]          src2,
  output logic                       aux_hazard,
  output logic                       pipe_stall,
  output logic                       rf_wb_en,
  output logic [ADDR_W-1:0]          rf_wb_dest,
  output logic [DATA_W-1:0]          rf_wb_value,
  output logic [$clog2(DEPTH):0]     aux_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] value;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic empty, full, force_grant, aux_grant, push, pop, hit;
  entry_t head;

  // Grant decision, FIFO bookkeeping and next-state computation.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    empty       = (count_q == '0);
    full        = (count_q == CNT_W'(DEPTH));
    force_grant = !empty && (wait_q >= WAIT_W'(MAX_WAIT));
    aux_grant   = !empty && (!pipe_wb_en || force_grant);
    // Full means no push even if the head leaves this cycle (no push-through).
    push        = aux_valid && !full;
    pop         = aux_grant;
    head        = mem_q[rd_ptr_q];

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    // Push and pop can only share a slot when the FIFO is full or empty,
    // and neither case allows both, so the order of these updates is free.
    valid_d = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;

    // Counts the cycles the head was denied. It restarts when the head
    // leaves or the FIFO is empty, and it stops at the force threshold.
    wait_d = wait_q;
    if (pop || empty)                       wait_d = '0;
    else if (wait_q < WAIT_W'(MAX_WAIT))    wait_d = wait_q + WAIT_W'(1);

    // The entry being popped this cycle is still valid, so it still flags.
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].dest == src1 || mem_q[i].dest == src2)) hit = 1'b1;
    end
  end

  // Drives the outputs. The enables are masked while reset is held.
  always_comb begin
    aux_ready   = rst && !full;
    aux_hazard  = rst && hit;
    pipe_stall  = rst && force_grant && pipe_wb_en;
    rf_wb_en    = rst && (aux_grant || pipe_wb_en);
    rf_wb_dest  = aux_grant ? head.dest  : pipe_wb_dest;
    rf_wb_value = aux_grant ? head.value : pipe_wb_value;
    aux_count   = count_q;
  end

  // Control state: pointers, occupancy, valid bits and the starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      wait_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      wait_q   <= wait_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; valid_q and count_q already make stale contents unobservable.
    if (push) mem_q[wr_ptr_q] <= '{dest: aux_dest, value: aux_value};
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter. A queue-based reference model
// predicts every output each cycle. Directed steps run first, then
// randomized traffic follows.
module tb_rf_write_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;

  typedef struct {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] value;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              pipe_wb_en = 1'b0;
  logic [ADDR_W-1:0] pipe_wb_dest = '0;
  logic [DATA_W-1:0] pipe_wb_value = '0;
  logic              aux_valid = 1'b0;
  logic [ADDR_W-1:0] aux_dest = '0;
  logic [DATA_W-1:0] aux_value = '0;
  logic [ADDR_W-1:0] src1 = '0, src2 = '0;
  logic              aux_ready, aux_hazard, pipe_stall, rf_wb_en;
  logic [ADDR_W-1:0] rf_wb_dest;
  logic [DATA_W-1:0] rf_wb_value;
  logic [$clog2(DEPTH):0] aux_count;

  rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_wb_dest(pipe_wb_dest), .pipe_wb_value(pipe_wb_value),
    .aux_valid(aux_valid), .aux_dest(aux_dest), .aux_value(aux_value), .aux_ready(aux_ready),
    .src1(src1), .src2(src2), .aux_hazard(aux_hazard), .pipe_stall(pipe_stall),
    .rf_wb_en(rf_wb_en), .rf_wb_dest(rf_wb_dest), .rf_wb_value(rf_wb_value),
    .aux_count(aux_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered aux writes in arrival order, plus the number
  // of consecutive cycles the head has been refused.
  wr_t q[$];
  int  wait_n = 0;

  // Snapshot of the outputs sampled in the most recent step.
  logic obs_en, obs_stall, obs_ready, obs_hazard;
  logic [ADDR_W-1:0] obs_dest;
  logic [DATA_W-1:0] obs_value;
  int   obs_count;
  logic last_stall, last_accept;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive at negedge, check against the model, then advance the model at posedge.
  task automatic step(input logic r, input logic pen, input logic [ADDR_W-1:0] pd,
                      input logic [DATA_W-1:0] pv, input logic av, input logic [ADDR_W-1:0] ad,
                      input logic [DATA_W-1:0] avl, input logic [ADDR_W-1:0] s1,
                      input logic [ADDR_W-1:0] s2);
    bit emp, ful, frc, gnt, hz, acc;
    logic exp_en, exp_stall, exp_ready, exp_hz;
    logic [ADDR_W-1:0] exp_dest;
    logic [DATA_W-1:0] exp_value;
    @(negedge clk);
    rst = r; pipe_wb_en = pen; pipe_wb_dest = pd; pipe_wb_value = pv;
    aux_valid = av; aux_dest = ad; aux_value = avl; src1 = s1; src2 = s2;
    #1;
    if (!r) begin
      q.delete();
      wait_n = 0;
    end
    emp = (q.size() == 0);
    ful = (q.size() == DEPTH);
    frc = !emp && (wait_n >= MAX_WAIT);
    gnt = !emp && (!pen || frc);
    hz  = 0;
    foreach (q[i]) if (q[i].dest == s1 || q[i].dest == s2) hz = 1;
    exp_en    = r && (gnt || pen);
    exp_stall = r && frc && pen;
    exp_ready = r && !ful;
    exp_hz    = r && hz;
    exp_dest  = gnt ? q[0].dest  : pd;
    exp_value = gnt ? q[0].value : pv;

    obs_en = rf_wb_en; obs_stall = pipe_stall; obs_ready = aux_ready; obs_hazard = aux_hazard;
    obs_dest = rf_wb_dest; obs_value = rf_wb_value; obs_count = int'(aux_count);

    check("rf_wb_en",   64'(rf_wb_en),   64'(exp_en));
    check("pipe_stall", 64'(pipe_stall), 64'(exp_stall));
    check("aux_ready",  64'(aux_ready),  64'(exp_ready));
    check("aux_hazard", 64'(aux_hazard), 64'(exp_hz));
    check("aux_count",  64'(aux_count),  64'(q.size()));
    if (exp_en) begin
      check("rf_wb_dest",  64'(rf_wb_dest),  64'(exp_dest));
      check("rf_wb_value", 64'(rf_wb_value), 64'(exp_value));
    end

    acc = r && av && !ful;
    last_stall  = exp_stall;
    last_accept = acc;
    @(posedge clk);
    if (r) begin
      if (gnt) void'(q.pop_front());
      if (acc) q.push_back('{dest: ad, value: avl});
      if (gnt || emp)          wait_n = 0;
      else if (wait_n < MAX_WAIT) wait_n++;
    end
  endtask

  // Pipe idle, no aux request, no reads of interest.
  task automatic idle(input logic r);
    step(r, 0, 0, 0, 0, 0, 0, 4'hF, 4'hF);
  endtask

  initial begin : stimulus
    logic pen, av;
    logic [ADDR_W-1:0] pd, ad;
    logic [DATA_W-1:0] pv, avl;
    int n;

    // Reset, then a pipe write after the release.
    step(0, 1, 3, 32'h11, 0, 0, 0, 0, 0);
    check("reset_en_low",    64'(obs_en),    64'(0));
    check("reset_ready_low", 64'(obs_ready), 64'(0));
    step(1, 1, 3, 32'h11, 0, 0, 0, 0, 0);
    check("release_dest",  64'(obs_dest),  64'(3));
    check("release_value", 64'(obs_value), 64'(32'h11));
    check("release_stall", 64'(obs_stall), 64'(0));

    // An aux write fills a pipe gap on the cycle after it is accepted.
    step(1, 0, 0, 0, 1, 5, 32'hAB, 0, 0);
    check("gap_no_bypass", 64'(obs_en), 64'(0));
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("gap_count_1", 64'(obs_count), 64'(1));
    check("gap_dest",    64'(obs_dest),  64'(5));
    check("gap_value",   64'(obs_value), 64'(32'hAB));
    idle(1);
    check("gap_count_0", 64'(obs_count), 64'(0));

    // Starvation: four pipe writes go through, the fifth cycle is stalled for the aux write.
    step(1, 1, 1, 32'h100, 1, 7, 32'hCC, 0, 0);
    for (int i = 0; i < MAX_WAIT; i++) begin
      step(1, 1, 1, 32'h100, 0, 0, 0, 0, 0);
      check("starve_no_stall", 64'(obs_stall), 64'(0));
    end
    step(1, 1, 1, 32'h100, 0, 0, 0, 0, 0);
    check("starve_stall", 64'(obs_stall), 64'(1));
    check("starve_dest",  64'(obs_dest),  64'(7));
    step(1, 1, 1, 32'h100, 0, 0, 0, 0, 0);
    check("starve_held_dest", 64'(obs_dest),  64'(1));
    check("starve_after",     64'(obs_stall), 64'(0));

    // A full FIFO refuses a third request until a pop frees a slot.
    step(1, 1, 2, 32'h200, 1, 1, 32'hA1, 0, 0);
    step(1, 1, 2, 32'h200, 1, 2, 32'hA2, 0, 0);
    step(1, 1, 2, 32'h200, 1, 4, 32'hA4, 0, 0);
    check("full_ready", 64'(obs_ready), 64'(0));
    check("full_count", 64'(obs_count), 64'(2));
    n = 0;
    while (!last_accept && n < 20) begin
      step(1, 1, 2, 32'h200, 1, 4, 32'hA4, 0, 0);
      n++;
    end
    check("full_third_accepted", 64'(last_accept), 64'(1));
    for (int i = 0; i < 3; i++) idle(1);
    check("full_drained", 64'(obs_count), 64'(0));

    // Hazard on a buffered destination clears once the entry is written.
    step(1, 1, 2, 32'h300, 1, 9, 32'h99, 0, 0);
    step(1, 1, 2, 32'h300, 0, 0, 0, 0, 9);
    check("hazard_set", 64'(obs_hazard), 64'(1));
    step(1, 0, 0, 0, 0, 0, 0, 0, 9);
    check("hazard_on_pop", 64'(obs_hazard), 64'(1));
    step(1, 0, 0, 0, 0, 0, 0, 0, 9);
    check("hazard_clear", 64'(obs_hazard), 64'(0));

    // Reset during operation discards the buffered entries.
    step(1, 1, 2, 32'h400, 1, 6, 32'h61, 0, 0);
    step(1, 1, 2, 32'h400, 1, 8, 32'h81, 0, 0);
    step(0, 1, 2, 32'h400, 0, 0, 0, 0, 0);
    check("midrst_count", 64'(obs_count), 64'(0));
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("midrst_no_write", 64'(obs_en), 64'(0));
    end

    // Random traffic. A stalled WB write and an unaccepted aux request are both held.
    pen = 0; pd = 0; pv = 0; av = 0; ad = 0; avl = 0;
    last_stall = 0; last_accept = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r;
      if (!last_stall) begin
        pen = ($urandom_range(0, 99) < 70);
        pd  = ADDR_W'($urandom);
        pv  = $urandom;
      end
      if (!av || last_accept) begin
        av  = ($urandom_range(0, 99) < 45);
        ad  = ADDR_W'($urandom);
        avl = $urandom;
      end
      r = ($urandom_range(0, 199) != 0);
      step(r, pen, pd, pv, av, ad, avl, ADDR_W'($urandom), ADDR_W'($urandom));
      if (!r) begin
        last_stall = 0;
        av = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
